mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised pipeline memory-access stage between EX and WB. Accepts one instruction per valid/ready handshake and forwards ALU results directly. Loads and stores go over a decoupled request/response data-memory port with byte-lane alignment, store strobes, sign/zero extension and misalignment detection. The result is held in a registered output slot toward WB.

## Interface
Parameters:
- XLEN, 32, datapath and address width; legal values 32 or 64. NB = XLEN/8 bytes per word, OW = log2(NB) offset bits.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clock edge)
- ms_valid  in  1  upstream instruction valid
- ms_ready  out  1  stage can accept this cycle
- ms_bits_pc  in  XLEN  instruction PC
- ms_bits_alu_res  in  XLEN  ALU result; effective address for memory ops
- ms_bits_store_data  in  XLEN  store source (low bytes used)
- ms_bits_mem_read  in  1  load
- ms_bits_mem_write  in  1  store
- ms_bits_mem_size  in  2  0=B, 1=H, 2=W, 3=D
- ms_bits_mem_unsigned  in  1  zero-extend load result
- ms_bits_rf_we  in  1  register write enable
- ms_bits_rf_waddr  in  5  destination register
- tows_ready  in  1  WB accepts
- tows_valid  out  1  output slot valid
- tows_bits_pc  out  XLEN  forwarded PC
- tows_bits_rf_we  out  1  write enable (forced 0 on error)
- tows_bits_rf_waddr  out  5  destination
- tows_bits_rf_wdata  out  XLEN  writeback data
- tows_bits_mem_err  out  1  misaligned/illegal access flag
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_wr  out  1  1 = store
- dmem_req_addr  out  XLEN  word-aligned address (low OW bits zero)
- dmem_req_wdata  out  XLEN  lane-shifted store data
- dmem_req_wstrb  out  NB  byte strobes (0 for loads)
- dmem_resp_valid  in  1  response valid (one per request, loads and stores)
- dmem_resp_rdata  in  XLEN  full aligned word

## Operation
- FSM states: IDLE, REQ, WAIT, OUT. Reset state is IDLE.
- At most one memory transaction is outstanding. Request fields come from registers and are stable while dmem_req_valid = 1.
- **ms_ready** = (state == IDLE) | (state == OUT & tows_ready).
- **Accept** (ms_valid & ms_ready): capture bits. Compute off = alu_res[OW-1:0].
- **Error** = mem_read & mem_write, or size 3 with XLEN = 32, or off not a multiple of (1 << size).
- On accept, next-state decision:
  - Memory op without error: go to REQ.
  - Otherwise: go to OUT. The slot gets wdata = alu_res for non-memory ops. On error, the slot gets wdata = 0, rf_we = 0, mem_err = 1.
- **REQ**: dmem_req_valid = 1. On dmem_req_ready, go to WAIT.
- **WAIT**: on dmem_resp_valid, go to OUT.
  - Load: wdata = (resp_rdata >> 8·off) truncated to 8 << size bits, then sign- or zero-extended per mem_unsigned.
  - Store: wdata = alu_res, rf_we passed through.
- **OUT**: tows_valid = 1 and the slot is held stable. On tows_ready: a simultaneous accept follows the accept rules above; otherwise go to IDLE.
- **Store encoding**:
  - wdata = store_data << 8·off.
  - wstrb = ((1 << (1 << size)) − 1) << off, truncated to NB bits.
- Non-memory instructions never touch dmem.
- dmem_resp_valid outside WAIT is ignored.
- Reset has priority over every event, including mid-REQ/WAIT. The in-flight transaction is abandoned and its late response is ignored.

## Timing
- Reset values: state = IDLE, tows_valid = 0, dmem_req_valid = 0, and every tows_bits_* and dmem_req_* output = 0. ms_ready = 1 once reset deasserts.
- Non-memory op: accepted in cycle N, tows_valid in N+1. Sustains 1 op/cycle when tows_ready is held high.
- Memory op: accepted in N, dmem_req_valid in N+1. With req_ready in N+1 and resp_valid in N+2, tows_valid is in N+3.
- Each extra cycle of req_ready or resp_valid delay adds one cycle of latency.
- Back-pressure: with tows_ready = 0 in OUT, ms_ready = 0 and all tows outputs are held unchanged.
- No combinational path from dmem_resp_* to tows_* or from tows_ready to dmem_req_*. tows_ready → ms_ready is combinational.

## Test plan
- XLEN=32, lb, addr 0x80000003, resp_rdata 0x80ABCDEF → dmem_req_addr 0x80000000, wstrb 0x0, rf_wdata 0xFFFFFF80. Repeated with lbu → 0x00000080.
- sh, addr 0x00001002, store_data 0x00001234 → req_wr = 1, addr 0x00001000, wdata 0x12340000, wstrb 0b1100. Response completes with rf_we = 0 as supplied.
- lw, addr 0x00001001 → no dmem_req_valid, tows_valid the next cycle, mem_err = 1, rf_we = 0, rf_wdata 0. Same result for XLEN=32 with size 3.
- Three back-to-back ALU ops with tows_ready = 1 → three consecutive tows_valid cycles carrying each alu_res. Then tows_ready = 0 for 3 cycles → outputs frozen and ms_ready = 0.
- Load with req_ready delayed 2 cycles and resp delayed 3 → req fields stable throughout, tows_valid exactly one cycle after resp_valid.
- reset = 0 during WAIT, then a response arrives after release → state IDLE, tows_valid stays 0, response ignored. The next ALU op completes normally.
- XLEN=64, ld at 0x…0, resp 0x8000_0000_0000_0001 → rf_wdata equals the response. lw at off 4, signed, with resp upper word 0x80000000 → rf_wdata 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX->WB memory stage with a decoupled, byte-lane aligned data-memory port
module mem_access_stage #(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ms_valid,
  output logic            ms_ready,
  input  logic [XLEN-1:0] ms_bits_pc,
  input  logic [XLEN-1:0] ms_bits_alu_res,
  input  logic [XLEN-1:0] ms_bits_store_data,
  input  logic            ms_bits_mem_read,
  input  logic            ms_bits_mem_write,
  input  logic [1:0]      ms_bits_mem_size,
  input  logic            ms_bits_mem_unsigned,
  input  logic            ms_bits_rf_we,
  input  logic [4:0]      ms_bits_rf_waddr,
  input  logic            tows_ready,
  output logic            tows_valid,
  output logic [XLEN-1:0] tows_bits_pc,
  output logic            tows_bits_rf_we,
  output logic [4:0]      tows_bits_rf_waddr,
  output logic [XLEN-1:0] tows_bits_rf_wdata,
  output logic            tows_bits_mem_err,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_wr,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [NB-1:0]   dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_alu;
  logic            r_read, r_uns, r_we;
  logic [1:0]      r_size;
  logic [OW-1:0]   r_off;
  logic [4:0]      r_waddr;
  logic [OW-1:0]   w_off, w_mask;
  logic            w_mem, w_err, w_go, w_acc;
  logic [3:0]      w_bytes;
  logic [NB-1:0]   w_strb;
  logic [XLEN-1:0] w_sdata, w_sh, w_ld;
  assign ms_ready = (r_state == IDLE) | ((r_state == OUT) & tows_ready);
  assign w_acc    = ms_valid & ms_ready;
  assign w_off    = ms_bits_alu_res[OW-1:0];
  assign w_bytes  = 4'd1 << ms_bits_mem_size;
  assign w_mask   = OW'(w_bytes - 4'd1);
  assign w_mem    = ms_bits_mem_read | ms_bits_mem_write;
  assign w_err    = w_mem & ((ms_bits_mem_read & ms_bits_mem_write) |
                             (ms_bits_mem_size == 2'd3 && XLEN == 32) | (|(w_off & w_mask)));
  assign w_go     = w_mem & ~w_err;
  assign w_strb   = NB'(((16'd1 << w_bytes) - 16'd1) << w_off);
  assign w_sdata  = ms_bits_store_data << {w_off, 3'b000};
  assign w_sh     = dmem_resp_rdata >> {r_off, 3'b000};
  assign w_ld     = r_size == 2'd0 ? (r_uns ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]))) :
                    r_size == 2'd1 ? (r_uns ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]))) :
                    r_size == 2'd2 ? (r_uns ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]))) : w_sh;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_pc               <= '0;
      r_alu              <= '0;
      r_read             <= 1'b0;
      r_uns              <= 1'b0;
      r_we               <= 1'b0;
      r_size             <= '0;
      r_off              <= '0;
      r_waddr            <= '0;
      tows_valid         <= 1'b0;
      tows_bits_pc       <= '0;
      tows_bits_rf_we    <= 1'b0;
      tows_bits_rf_waddr <= '0;
      tows_bits_rf_wdata <= '0;
      tows_bits_mem_err  <= 1'b0;
      dmem_req_valid     <= 1'b0;
      dmem_req_wr        <= 1'b0;
      dmem_req_addr      <= '0;
      dmem_req_wdata     <= '0;
      dmem_req_wstrb     <= '0;
    end else if (w_acc) begin
      r_pc           <= ms_bits_pc;
      r_alu          <= ms_bits_alu_res;
      r_read         <= ms_bits_mem_read;
      r_uns          <= ms_bits_mem_unsigned;
      r_we           <= ms_bits_rf_we;
      r_size         <= ms_bits_mem_size;
      r_off          <= w_off;
      r_waddr        <= ms_bits_rf_waddr;
      r_state        <= w_go ? REQ : OUT;
      tows_valid     <= ~w_go;
      dmem_req_valid <= w_go;
      if (w_go) begin
        dmem_req_wr    <= ms_bits_mem_write;
        dmem_req_addr  <= {ms_bits_alu_res[XLEN-1:OW], OW'(0)};
        dmem_req_wdata <= w_sdata;
        dmem_req_wstrb <= ms_bits_mem_write ? w_strb : '0;
      end else begin
        tows_bits_pc       <= ms_bits_pc;
        tows_bits_rf_we    <= ms_bits_rf_we & ~w_err;
        tows_bits_rf_waddr <= ms_bits_rf_waddr;
        tows_bits_rf_wdata <= w_err ? '0 : ms_bits_alu_res;
        tows_bits_mem_err  <= w_err;
      end
    end else if (r_state == REQ && dmem_req_ready) begin
      r_state        <= WAIT;
      dmem_req_valid <= 1'b0;
    end else if (r_state == WAIT && dmem_resp_valid) begin
      r_state            <= OUT;
      tows_valid         <= 1'b1;
      tows_bits_pc       <= r_pc;
      tows_bits_rf_we    <= r_we;
      tows_bits_rf_waddr <= r_waddr;
      tows_bits_rf_wdata <= r_read ? w_ld : r_alu;
      tows_bits_mem_err  <= 1'b0;
    end else if (r_state == OUT && tows_ready) begin
      r_state    <= IDLE;
      tows_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed literal checks plus randomized traffic against a transaction-level model
module tb_mem_access_stage;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  logic ms_valid, ms_ready, rd, wr, uns, we;
  logic [31:0] pc, alu, sd;
  logic [1:0] size;
  logic [4:0] waddr;
  logic tows_ready, tows_valid, t_we, t_err;
  logic [31:0] t_pc, t_wdata;
  logic [4:0] t_waddr;
  logic req_valid, req_ready, req_wr, resp_valid;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0] req_wstrb;
  logic x_ms_valid, x_ms_ready, x_rd, x_wr, x_uns, x_tows_ready, x_tows_valid, x_t_we, x_t_err;
  logic [63:0] x_pc, x_alu, x_sd, x_t_pc, x_t_wdata, x_req_addr, x_req_wdata, x_resp_rdata;
  logic [1:0] x_size;
  logic [4:0] x_t_waddr;
  logic x_req_valid, x_req_ready, x_req_wr, x_resp_valid;
  logic [7:0] x_req_wstrb;
  int n_tests = 0, n_fail = 0;

  mem_access_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .ms_valid(ms_valid), .ms_ready(ms_ready),
    .ms_bits_pc(pc), .ms_bits_alu_res(alu), .ms_bits_store_data(sd),
    .ms_bits_mem_read(rd), .ms_bits_mem_write(wr), .ms_bits_mem_size(size),
    .ms_bits_mem_unsigned(uns), .ms_bits_rf_we(we), .ms_bits_rf_waddr(waddr),
    .tows_ready(tows_ready), .tows_valid(tows_valid), .tows_bits_pc(t_pc),
    .tows_bits_rf_we(t_we), .tows_bits_rf_waddr(t_waddr), .tows_bits_rf_wdata(t_wdata),
    .tows_bits_mem_err(t_err), .dmem_req_valid(req_valid), .dmem_req_ready(req_ready),
    .dmem_req_wr(req_wr), .dmem_req_addr(req_addr), .dmem_req_wdata(req_wdata),
    .dmem_req_wstrb(req_wstrb), .dmem_resp_valid(resp_valid), .dmem_resp_rdata(resp_rdata));

  mem_access_stage #(.XLEN(64)) dut64 (
    .clock(clock), .reset(reset), .ms_valid(x_ms_valid), .ms_ready(x_ms_ready),
    .ms_bits_pc(x_pc), .ms_bits_alu_res(x_alu), .ms_bits_store_data(x_sd),
    .ms_bits_mem_read(x_rd), .ms_bits_mem_write(x_wr), .ms_bits_mem_size(x_size),
    .ms_bits_mem_unsigned(x_uns), .ms_bits_rf_we(1'b1), .ms_bits_rf_waddr(5'd7),
    .tows_ready(x_tows_ready), .tows_valid(x_tows_valid), .tows_bits_pc(x_t_pc),
    .tows_bits_rf_we(x_t_we), .tows_bits_rf_waddr(x_t_waddr), .tows_bits_rf_wdata(x_t_wdata),
    .tows_bits_mem_err(x_t_err), .dmem_req_valid(x_req_valid), .dmem_req_ready(x_req_ready),
    .dmem_req_wr(x_req_wr), .dmem_req_addr(x_req_addr), .dmem_req_wdata(x_req_wdata),
    .dmem_req_wstrb(x_req_wstrb), .dmem_resp_valid(x_resp_valid), .dmem_resp_rdata(x_resp_rdata));

  typedef struct {
    logic [31:0] pc;
    logic we;
    logic [4:0] waddr;
    logic [31:0] wdata;
    logic err;
  } res_t;
  res_t q[$];
  bit req_pend = 0, awaiting = 0, after_rst = 0;
  logic [31:0] e_addr, e_wdata, p_pc, p_alu;
  logic e_wr, p_rd, p_uns, p_we;
  logic [3:0] e_strb;
  logic [4:0] p_waddr;
  int p_size, p_off;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // one clock of the 32-bit DUT: compare against the model, then advance the model past the edge
  task automatic step();
    bit rdy;
    logic [63:0] v, mask;
    int off, nb, bits;
    chk("tows_valid", tows_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tows_pc", t_pc, q[0].pc);
      chk("tows_we", t_we, q[0].we);
      chk("tows_waddr", t_waddr, q[0].waddr);
      chk("tows_wdata", t_wdata, q[0].wdata);
      chk("tows_err", t_err, q[0].err);
    end
    chk("req_valid", req_valid, req_pend);
    if (req_pend) begin
      chk("req_addr", req_addr, e_addr);
      chk("req_wr", req_wr, e_wr);
      chk("req_wstrb", req_wstrb, e_strb);
      if (e_wr) chk("req_wdata", req_wdata, e_wdata);
    end
    if (after_rst)
      chk("reset_zero", {t_pc, t_we, t_waddr, t_err, req_wr, req_wstrb, (|t_wdata), (|req_addr), (|req_wdata)}, 0);
    #1;
    after_rst = 0;
    if (!reset) begin
      q.delete();
      req_pend = 0;
      awaiting = 0;
      after_rst = 1;
    end else begin
      rdy = !req_pend && !awaiting && (q.size() == 0 || tows_ready);
      chk("ms_ready", ms_ready, rdy);
      if (q.size() != 0 && tows_ready) void'(q.pop_front());
      if (awaiting && resp_valid) begin
        awaiting = 0;
        if (p_rd) begin
          bits = 8 << p_size;
          mask = (64'd1 << bits) - 64'd1;
          v = ({32'd0, resp_rdata} >> (8 * p_off)) & mask;
          if (!p_uns && v[bits-1]) v = v | ~mask;
          q.push_back('{p_pc, p_we, p_waddr, v[31:0], 1'b0});
        end else q.push_back('{p_pc, p_we, p_waddr, p_alu, 1'b0});
      end
      if (req_pend && req_ready) begin
        req_pend = 0;
        awaiting = 1;
      end
      if (ms_valid && rdy) begin
        off = int'(alu % 4);
        nb = 1 << size;
        if ((rd || wr) && !(rd && wr) && size != 3 && off % nb == 0) begin
          req_pend = 1;
          e_addr = alu - alu % 4;
          e_wr = wr;
          e_wdata = sd << (8 * off);
          e_strb = wr ? 4'((((1 << nb) - 1) << off) % 16) : 4'd0;
          p_pc = pc; p_alu = alu; p_rd = rd; p_uns = uns; p_we = we; p_waddr = waddr;
          p_size = int'(size); p_off = off;
        end else if (rd || wr) q.push_back('{pc, 1'b0, waddr, 32'd0, 1'b1});
        else q.push_back('{pc, we, waddr, alu, 1'b0});
      end
    end
    @(negedge clock);
  endtask

  task automatic mem_op(input bit rd_i, input bit wr_i, input bit uns_i, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int rq_dly, input int rs_dly, input logic [31:0] x_addr,
                        input logic [31:0] x_wd, input logic [3:0] x_strb, input logic [31:0] x_res,
                        input bit x_we);
    ms_valid = 1; rd = rd_i; wr = wr_i; uns = uns_i; size = sz; alu = addr; sd = sdata;
    pc = 32'h400; we = x_we; waddr = 5'd3;
    tows_ready = 1; req_ready = 0; resp_valid = 0;
    step();
    ms_valid = 0;
    for (int i = 0; i <= rq_dly; i++) begin
      chk("lit_req_valid", req_valid, 1);
      chk("lit_req_addr", req_addr, x_addr);
      chk("lit_req_wr", req_wr, wr_i);
      chk("lit_req_wstrb", req_wstrb, x_strb);
      if (wr_i) chk("lit_req_wdata", req_wdata, x_wd);
      req_ready = (i == rq_dly);
      step();
    end
    req_ready = 0;
    for (int i = 0; i < rs_dly; i++) begin
      chk("lit_wait_tows", tows_valid, 0);
      chk("lit_wait_req", req_valid, 0);
      step();
    end
    resp_valid = 1; resp_rdata = rdata;
    step();
    resp_valid = 0;
    chk("lit_tows_valid", tows_valid, 1);
    chk("lit_tows_wdata", t_wdata, x_res);
    chk("lit_tows_we", t_we, x_we);
    chk("lit_tows_err", t_err, 0);
    step();
  endtask

  task automatic bad_op(input logic [1:0] sz, input logic [31:0] addr);
    ms_valid = 1; rd = 1; wr = 0; size = sz; alu = addr; we = 1; tows_ready = 1;
    step();
    ms_valid = 0;
    chk("lit_err_valid", tows_valid, 1);
    chk("lit_err_flag", t_err, 1);
    chk("lit_err_we", t_we, 0);
    chk("lit_err_wdata", t_wdata, 0);
    chk("lit_err_noreq", req_valid, 0);
    step();
  endtask

  task automatic op64(input bit rd_i, input bit wr_i, input logic [1:0] sz, input logic [63:0] addr,
                      input logic [63:0] sdata, input logic [63:0] rdata, input logic [63:0] x_addr,
                      input logic [63:0] x_wd, input logic [7:0] x_strb, input logic [63:0] x_res);
    x_ms_valid = 1; x_rd = rd_i; x_wr = wr_i; x_uns = 0; x_size = sz; x_alu = addr; x_sd = sdata;
    x_pc = 64'h8000; x_tows_ready = 1; x_req_ready = 1; x_resp_valid = 0;
    @(negedge clock);
    x_ms_valid = 0;
    chk("x64_req_valid", x_req_valid, 1);
    chk("x64_req_addr", x_req_addr, x_addr);
    chk("x64_req_wstrb", x_req_wstrb, x_strb);
    if (wr_i) chk("x64_req_wdata", x_req_wdata, x_wd);
    @(negedge clock);
    x_req_ready = 0; x_resp_valid = 1; x_resp_rdata = rdata;
    @(negedge clock);
    x_resp_valid = 0;
    chk("x64_tows_valid", x_tows_valid, 1);
    chk("x64_tows_wdata", x_t_wdata, x_res);
    chk("x64_tows_err", x_t_err, 0);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] vals [3];
    int kind;
    reset = 0;
    {ms_valid, rd, wr, uns, we, tows_ready, req_ready, resp_valid} = '0;
    {pc, alu, sd, resp_rdata, size, waddr} = '0;
    {x_ms_valid, x_rd, x_wr, x_uns, x_tows_ready, x_req_ready, x_resp_valid} = '0;
    {x_pc, x_alu, x_sd, x_resp_rdata, x_size} = '0;
    @(negedge clock);
    step();
    reset = 1;
    #1;
    chk("reset_ms_ready", ms_ready, 1);
    chk("reset_x64", {x_tows_valid, x_req_valid, (|x_req_addr), (|x_t_wdata), x_req_wstrb}, 0);
    step();
    mem_op(1, 0, 0, 2'd0, 32'h80000003, 32'h0, 32'h80ABCDEF, 0, 0, 32'h80000000, 32'h0, 4'h0, 32'hFFFFFF80, 1);
    mem_op(1, 0, 1, 2'd0, 32'h80000003, 32'h0, 32'h80ABCDEF, 0, 0, 32'h80000000, 32'h0, 4'h0, 32'h00000080, 1);
    mem_op(0, 1, 0, 2'd1, 32'h00001002, 32'h00001234, 32'h0, 0, 0, 32'h00001000, 32'h12340000, 4'b1100, 32'h00001002, 0);
    mem_op(1, 0, 0, 2'd1, 32'h00002006, 32'h0, 32'h7FFF1234, 2, 3, 32'h00002004, 32'h0, 4'h0, 32'h00007FFF, 1);
    mem_op(0, 1, 0, 2'd0, 32'h00002001, 32'h000000AB, 32'h0, 1, 1, 32'h00002000, 32'h0000AB00, 4'b0010, 32'h00002001, 1);
    bad_op(2'd2, 32'h00001001);
    bad_op(2'd3, 32'h00001000);
    vals = '{32'h11111111, 32'h22222222, 32'h33333333};
    tows_ready = 1;
    for (int k = 0; k < 3; k++) begin
      ms_valid = 1; rd = 0; wr = 0; alu = vals[k]; pc = 32'h100 + 4 * k;
      step();
      chk("b2b_valid", tows_valid, 1);
      chk("b2b_wdata", t_wdata, vals[k]);
    end
    ms_valid = 0; tows_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("freeze_ready", ms_ready, 0);
      chk("freeze_wdata", t_wdata, vals[2]);
      chk("freeze_pc", t_pc, 32'h108);
      step();
    end
    tows_ready = 1;
    step();
    ms_valid = 1; rd = 1; wr = 0; size = 2'd2; alu = 32'h3000;
    step();
    ms_valid = 0; req_ready = 1;
    step();
    req_ready = 0; reset = 0;
    step();
    reset = 1; resp_valid = 1; resp_rdata = 32'hDEADBEEF;
    step();
    chk("rst_tows_valid", tows_valid, 0);
    chk("rst_req_valid", req_valid, 0);
    step();
    chk("rst_late_resp", tows_valid, 0);
    resp_valid = 0; ms_valid = 1; rd = 0; alu = 32'h55;
    step();
    ms_valid = 0;
    chk("rst_alu_valid", tows_valid, 1);
    chk("rst_alu_wdata", t_wdata, 32'h55);
    step();
    op64(1, 0, 2'd3, 64'h0000_0000_8000_1000, 64'h0, 64'h8000_0000_0000_0001,
         64'h0000_0000_8000_1000, 64'h0, 8'h00, 64'h8000_0000_0000_0001);
    op64(1, 0, 2'd2, 64'h0000_0000_8000_1004, 64'h0, 64'h8000_0000_1234_5678,
         64'h0000_0000_8000_1000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0000);
    op64(0, 1, 2'd3, 64'h2000, 64'h1122_3344_5566_7788, 64'h0,
         64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 64'h2000);
    op64(0, 1, 2'd0, 64'h2005, 64'hAB, 64'h0, 64'h2000, 64'h0000_AB00_0000_0000, 8'h20, 64'h2005);
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom % 250) != 0;
      ms_valid = ($urandom % 3) != 0;
      pc = $urandom; alu = $urandom; sd = $urandom; we = $urandom; waddr = 5'($urandom);
      uns = $urandom;
      kind = $urandom % 8;
      rd = kind inside {3, 4, 7};
      wr = kind inside {5, 6, 7};
      size = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      if ($urandom % 4 != 0) alu = alu - alu % (32'd1 << size);
      tows_ready = ($urandom % 4) != 0;
      req_ready = ($urandom % 3) != 0;
      resp_valid = awaiting ? ($urandom % 2 == 0) : ($urandom % 5 == 0);
      resp_rdata = $urandom;
    end_of_cycle: step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
